// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default bit period, majority vote helper.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 217;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side handshake and status bundle between the UART receiver and its byte consumer.
interface uart_rx_os_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        o_rx_valid;
    logic                        i_rx_ready;
    logic [7:0]                  o_rx_data;
    logic                        o_frame_err;
    logic                        o_overrun;
    logic                        o_rx_busy;
    logic [$clog2(FIFO_DEPTH):0] o_fifo_count;

    modport master (
        output o_rx_valid, o_rx_data, o_frame_err, o_overrun, o_rx_busy, o_fifo_count,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_valid, o_rx_data, o_frame_err, o_overrun, o_rx_busy, o_fifo_count,
        output i_rx_ready
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Purpose: 8-bit synchronous FIFO, power-of-two depth, head exposed combinationally.
// Latency: a pushed byte is visible at the head the cycle after the push.
// Backpressure: push into a full FIFO is accepted only together with a pop; otherwise ignored.
module uart_sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   push,
    input  logic [7:0]             push_dat,
    input  logic                   pop,
    output logic [7:0]             pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);
    // Head reads as zero when empty so the output bus has a defined value out of reset.
    assign pop_dat = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Purpose: 8N1 UART receiver with 3-sample majority vote per bit, feeding a small byte FIFO.
// Latency: byte appears on o_rx_valid the cycle after the stop-bit decision (mid stop bit).
// Backpressure: i_rx_ready pops the FIFO head; a byte arriving at a full FIFO is dropped with o_overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         i_clk_sys,
    input  logic         i_rst_l,
    input  logic         i_rx_serial,
    uart_rx_os_if.master rx_if
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state;
    logic          sync1;
    logic          sync2;
    logic [1:0]    sync_vld;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          smp_a;
    logic          smp_b;
    logic [7:0]    shreg;
    logic          ferr_q;
    logic          ovr_q;

    logic          rx;
    logic          dec;
    logic          maj;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign rx   = sync2;
    assign dec  = (cnt == MID + 1'b1);
    assign maj  = maj3(smp_a, smp_b, rx);
    assign push = (state == STOP) && dec && maj;
    assign pop  = rx_if.o_rx_valid && rx_if.i_rx_ready;

    assign rx_if.o_rx_valid  = !fifo_empty;
    assign rx_if.o_rx_busy   = (state != IDLE);
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_overrun   = ovr_q;

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_l) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync_vld <= '0;
            state    <= WAIT_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            smp_a    <= 1'b0;
            smp_b    <= 1'b0;
            shreg    <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1    <= i_rx_serial;
            sync2    <= sync1;
            // The synchronizer's reset value is not a real observation of the line;
            // WAIT_IDLE only trusts sync2 once it carries a sampled value.
            sync_vld <= {sync_vld[0], 1'b1};
            ferr_q   <= 1'b0;
            ovr_q    <= push && fifo_full && !pop;
            cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == MID - 1'b1) smp_a <= rx;
            if (cnt == MID)        smp_b <= rx;

            case (state)
                WAIT_IDLE: if (rx && sync_vld[1]) state <= IDLE;
                IDLE: begin
                    if (!rx) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (dec && maj) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (dec) shreg <= {maj, shreg[7:1]};
                    if (cnt == LAST) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // Decide mid stop bit so back-to-back frames keep half a bit of margin.
                    if (dec) begin
                        if (maj) begin
                            state <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= WAIT_IDLE;
                        end
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (i_clk_sys),
        .rst_l    (i_rst_l),
        .push     (push),
        .push_dat (shreg),
        .pop      (pop),
        .pop_dat  (rx_if.o_rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rx_if.o_fifo_count)
    );

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning system clocks per bit (217 at 50 MHz is 230400 baud); legal values >= 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; power of two, >= 2.
REQ-003 i_clk_sys  input  1  system clock; single clock domain; all logic on rising edge.
REQ-004 i_rst_l  input  1  reset, synchronous and active-low.
REQ-005 i_rx_serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 o_rx_valid  output  1  FIFO head valid (FIFO non-empty).
REQ-007 i_rx_ready  input  1  consumer accepts head byte when high with o_rx_valid.
REQ-008 o_rx_data  output  8  FIFO head byte; stable while o_rx_valid is high and i_rx_ready is low.
REQ-009 o_frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-010 o_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 o_rx_busy  output  1  high in every state except IDLE.
REQ-012 o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 i_rx_serial SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value.
REQ-014 FSM states SHALL be WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-015 WAIT_IDLE -> IDLE when the synchronized line is 1; IDLE -> START on synchronized line 0; bit counter cleared on that transition.
REQ-016 Bit-window counter SHALL run 0..CLKS_PER_BIT-1 and wrap; windows are aligned to the detected start edge.
REQ-017 In each window, the line SHALL be sampled at counts M-1, M and M+1, with M = (CLKS_PER_BIT-1)/2 (integer division); the bit value is the 2-of-3 majority, decided at count M+1.
REQ-018 START: a majority of 1 is a false start and SHALL return to IDLE with no output; a majority of 0 goes to DATA at window end.
REQ-019 DATA: 8 bits SHALL be shifted LSB-first, one per window; after bit 7 the FSM goes to STOP at window end.
REQ-020 STOP: at the decision point, a majority of 1 pushes the byte and goes to IDLE immediately (no wait for window end); a majority of 0 pulses o_frame_err, discards the byte and goes to WAIT_IDLE.
REQ-021 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle; otherwise the byte is dropped and o_overrun pulses.
REQ-022 A pop occurs when o_rx_valid && i_rx_ready. Simultaneous push and pop leaves the count unchanged and preserves order.
REQ-023 A byte pushed into an empty FIFO SHALL appear on o_rx_valid/o_rx_data the cycle after the stop decision.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; i_rx_ready while empty has no effect.

Reset
REQ-025 While i_rst_l is low at a clock edge: FSM enters WAIT_IDLE; counters, shift register and FIFO pointers are zeroed; o_rx_valid=0, o_rx_data=0, o_frame_err=0, o_overrun=0, o_rx_busy=1 (WAIT_IDLE), o_fifo_count=0.
REQ-026 Reset mid-byte SHALL discard the partial byte; after release, no start is detected until the line has been seen high.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT constant.
REQ-028 The FIFO SHALL be a sub-module uart_sync_fifo (depth-parameterized, 8-bit, push/pop/full/empty/count); the FSM and sampler SHALL be in uart_rx_os.

Verification (CLKS_PER_BIT=217, 50 MHz)
REQ-029 Send 0xA5 8N1 with ready high -> exactly one o_rx_valid cycle with o_rx_data=0xA5, no error pulses, o_rx_busy low after the stop decision.
REQ-030 Drive a low glitch of 50 clocks in IDLE -> false start; no valid, no o_frame_err; o_rx_busy returns low by count M+1.
REQ-031 Send 0x3C with the stop bit low, hold the line low for 20 bit times, then high, then send 0x55 -> one o_frame_err pulse, no push, no restart while low, 0x55 then received correctly.
REQ-032 Hold ready low and send 0x01..0x05 -> o_fifo_count reaches 4, o_overrun pulses once on 0x05; drain returns 0x01, 0x02, 0x03, 0x04 in order.
REQ-033 Inject a 1-clock inverted spike at count M of data bit 3 while sending 0x00 -> majority rejects the spike and 0x00 is received.
REQ-034 Assert reset during data bit 4 with the line held low at release -> all outputs at reset values, no byte output, reception resumes only after the line goes high.
